pipe_skid_stage: RTL

- Parametrised pipeline-stage register, the successor to the fixed instruction/PC+4 latch between fetch and decode.
- Carries an arbitrary-width payload between any two pipeline stages, using a valid/ready handshake in both directions.
- An optional 2-entry skid buffer breaks the combinational ready path.
- Supports synchronous flush (bubble insertion) and counts upstream back-pressure cycles for performance monitoring.

---
 rtl/pipe_skid_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage register with an optional skid entry.
// It also has a synchronous flush and a saturating counter of upstream back-pressure cycles.
module pipe_skid_stage #(
    parameter int                 DATA_W    = 64,
    parameter int                 SKID      = 1,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
            main_q  <= FLUSH_VAL;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            stall_q <= stall_d;
        end
    end

    // The skid entry is only ever read while its state says it is valid.
    always_ff @(posedge CLK) begin
        skid_q <= skid_d;
    end

    // Next-state logic; flush overrides every handshake event.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (in_fire) state_d = ST_FULL;
                ST_FULL: begin
                    if (in_fire && !out_fire && (SKID != 0)) state_d = ST_SKID;
                    else if (!in_fire && out_fire)           state_d = ST_EMPTY;
                end
                ST_SKID:  if (out_fire) state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Outputs; with SKID=1 in_ready depends only on registered state.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        occupancy = state_q;
        if (SKID != 0) in_ready = (state_q != ST_SKID);
        else           in_ready = (state_q == ST_EMPTY) | out_ready;
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = FLUSH_VAL;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (in_fire) main_d = in_data;
                ST_FULL: begin
                    if (in_fire && out_fire) main_d = in_data;
                    else if (in_fire)        skid_d = in_data;
                    else if (out_fire)       main_d = FLUSH_VAL;
                end
                ST_SKID:  if (out_fire) main_d = skid_q;
                default:  main_d = FLUSH_VAL;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
    end

    assign out_data  = main_q;
    assign stall_cnt = stall_q;

endmodule
